tmr_scrub_regfile: RTL and testbench

//  Triplicated register file: the write side of our TMR scheme.
//  - Every write lands in three copies (A/B/C).
//  - Raw copies are exported for external majority voters; a locally voted word is also provided.
//  - A background scrubber walks all addresses, rewrites any word whose copies disagree with the bitwise majority, and logs each SEU.
//  - Sits between VME/config logic and consumers of TMR-protected settings.

---
 rtl/tmr_pkg.sv | 19 +
 rtl/tmr_maj3.sv | 13 +
 rtl/tmr_scrub_regfile.sv | 200 ++++++++++++++++++++
 tb/tb_tmr_scrub_regfile.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared encodings for the triplicated register file: scrub FSM states and
// the copy-select codes used by the fault-injection hook.
package tmr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_READ = 2'd2,
        S_FIX  = 2'd3
    } scrub_state_t;

    typedef enum logic [1:0] {
        INJ_A    = 2'd0,
        INJ_B    = 2'd1,
        INJ_C    = 2'd2,
        INJ_NONE = 2'd3
    } inj_sel_t;

endpackage

// File: rtl/tmr_maj3.sv
// Bitwise 2-of-3 majority of three equal-width words, purely combinational.
module tmr_maj3 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/tmr_scrub_regfile.sv
// Triplicated register file with registered raw/voted read ports and a
// background scrubber that rewrites disagreeing words with their majority.
module tmr_scrub_regfile
    import tmr_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int AWIDTH    = 4,
    parameter int SCRUB_DIV = 8,
    parameter int ECNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              inj_en,
    input  logic [1:0]        inj_sel,
    input  logic [WIDTH-1:0]  inj_mask,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic [WIDTH-1:0]  rdata_c,
    output logic [WIDTH-1:0]  rdata_v,
    input  logic              scrub_en,
    output logic              busy,
    output logic              seu_flag,
    output logic [AWIDTH-1:0] seu_addr,
    output logic [ECNT_W-1:0] seu_cnt,
    input  logic              cnt_clr
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int DIV_W = (SCRUB_DIV > 1) ? $clog2(SCRUB_DIV) : 1;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [WIDTH-1:0] mem_c [DEPTH];

    scrub_state_t      state, state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [AWIDTH-1:0] scrub_addr;
    logic [WIDTH-1:0]  snap_a, snap_b, snap_c;

    logic load_div, dec_div, snap_en, fix_commit, fix_write, mismatch;
    logic inj_a, inj_b, inj_c, fwd_hit;
    logic [WIDTH-1:0] wr_a, wr_b, wr_c;
    logic [WIDTH-1:0] vote_rd, vote_scrub;

    assign inj_a = inj_en && (inj_sel == INJ_A);
    assign inj_b = inj_en && (inj_sel == INJ_B);
    assign inj_c = inj_en && (inj_sel == INJ_C);
    assign wr_a  = inj_a ? (wdata ^ inj_mask) : wdata;
    assign wr_b  = inj_b ? (wdata ^ inj_mask) : wdata;
    assign wr_c  = inj_c ? (wdata ^ inj_mask) : wdata;

    // A user write landing on the scrub address during READ is forwarded into
    // the snapshot, so FIX always judges the data the array really holds.
    assign fwd_hit = we && (waddr == scrub_addr);

    tmr_maj3 #(.WIDTH(WIDTH)) u_maj_rd (
        .a(mem_a[raddr]),
        .b(mem_b[raddr]),
        .c(mem_c[raddr]),
        .y(vote_rd)
    );

    tmr_maj3 #(.WIDTH(WIDTH)) u_maj_scrub (
        .a(snap_a),
        .b(snap_b),
        .c(snap_c),
        .y(vote_scrub)
    );

    assign mismatch  = (snap_a != snap_b) || (snap_b != snap_c);
    assign fix_write = fix_commit && mismatch;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt  = state;
        load_div   = 1'b0;
        dec_div    = 1'b0;
        snap_en    = 1'b0;
        fix_commit = 1'b0;
        case (state)
            S_IDLE: begin
                if (scrub_en) begin
                    state_nxt = S_WAIT;
                    load_div  = 1'b1;
                end
            end
            S_WAIT: begin
                if (!scrub_en) begin
                    state_nxt = S_IDLE;
                end else if (div_cnt == '0) begin
                    state_nxt = S_READ;
                end else begin
                    dec_div = 1'b1;
                end
            end
            S_READ: begin
                if (!scrub_en) begin
                    state_nxt = S_IDLE;
                end else begin
                    snap_en   = 1'b1;
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                // A concurrent user write makes the snapshot untrustworthy: re-read.
                if (we) begin
                    state_nxt = S_READ;
                end else begin
                    fix_commit = 1'b1;
                    if (scrub_en) begin
                        state_nxt = S_WAIT;
                        load_div  = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            scrub_addr <= '0;
            snap_a     <= '0;
            snap_b     <= '0;
            snap_c     <= '0;
        end else begin
            state <= state_nxt;
            if (load_div) begin
                div_cnt <= DIV_W'(SCRUB_DIV - 1);
            end else if (dec_div) begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
            if (snap_en) begin
                snap_a <= fwd_hit ? wr_a : mem_a[scrub_addr];
                snap_b <= fwd_hit ? wr_b : mem_b[scrub_addr];
                snap_c <= fwd_hit ? wr_c : mem_c[scrub_addr];
            end
            if (fix_commit) begin
                scrub_addr <= scrub_addr + AWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
                mem_c[i] <= '0;
            end
        end else if (we) begin
            mem_a[waddr] <= wr_a;
            mem_b[waddr] <= wr_b;
            mem_c[waddr] <= wr_c;
        end else if (fix_write) begin
            mem_a[scrub_addr] <= vote_scrub;
            mem_b[scrub_addr] <= vote_scrub;
            mem_c[scrub_addr] <= vote_scrub;
        end
    end

    // Registered read port plus SEU reporting; clear and correction in the
    // same cycle leaves a count of exactly one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_a  <= '0;
            rdata_b  <= '0;
            rdata_c  <= '0;
            rdata_v  <= '0;
            seu_flag <= 1'b0;
            seu_addr <= '0;
            seu_cnt  <= '0;
        end else begin
            rdata_a  <= mem_a[raddr];
            rdata_b  <= mem_b[raddr];
            rdata_c  <= mem_c[raddr];
            rdata_v  <= vote_rd;
            seu_flag <= fix_write;
            if (fix_write) begin
                seu_addr <= scrub_addr;
                if (cnt_clr) begin
                    seu_cnt <= ECNT_W'(1);
                end else if (seu_cnt != {ECNT_W{1'b1}}) begin
                    seu_cnt <= seu_cnt + ECNT_W'(1);
                end
            end else if (cnt_clr) begin
                seu_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tmr_scrub_regfile.sv
// Directed bench for tmr_scrub_regfile with a word-level behavioural model
// checked against every output on every cycle after reset.
module tb_tmr_scrub_regfile;

    localparam int WIDTH     = 16;
    localparam int AWIDTH    = 4;
    localparam int DEPTH     = 16;
    localparam int SCRUB_DIV = 8;
    localparam int ECNT_W    = 8;
    localparam int STEP      = SCRUB_DIV + 2;

    localparam int PH_OFF  = 0;
    localparam int PH_GAP  = 1;
    localparam int PH_SNAP = 2;
    localparam int PH_FIX  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, we, inj_en, scrub_en, cnt_clr;
    logic [AWIDTH-1:0] waddr, raddr;
    logic [WIDTH-1:0]  wdata, inj_mask;
    logic [1:0]        inj_sel;
    logic [WIDTH-1:0]  rdata_a, rdata_b, rdata_c, rdata_v;
    logic              busy, seu_flag;
    logic [AWIDTH-1:0] seu_addr;
    logic [ECNT_W-1:0] seu_cnt;

    tmr_scrub_regfile #(
        .WIDTH(WIDTH), .AWIDTH(AWIDTH), .SCRUB_DIV(SCRUB_DIV), .ECNT_W(ECNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask), .raddr(raddr),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .rdata_c(rdata_c), .rdata_v(rdata_v),
        .scrub_en(scrub_en), .busy(busy), .seu_flag(seu_flag), .seu_addr(seu_addr),
        .seu_cnt(seu_cnt), .cnt_clr(cnt_clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: three arrays, a scrub pointer and a coarse phase.
    logic [WIDTH-1:0] ma [DEPTH];
    logic [WIDTH-1:0] mb [DEPTH];
    logic [WIDTH-1:0] mc [DEPTH];
    int ph, gap, sptr, e_cnt;
    logic [WIDTH-1:0] e_ra, e_rb, e_rc, e_rv;
    logic e_flag;
    int e_addr;
    bit mvalid = 1'b0;

    function automatic logic [WIDTH-1:0] vote(input logic [WIDTH-1:0] a, b, c);
        logic [WIDTH-1:0] y;
        for (int i = 0; i < WIDTH; i++)
            y[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
        return y;
    endfunction

    function automatic bit differs(input int ad);
        return (ma[ad] != mb[ad]) || (mb[ad] != mc[ad]);
    endfunction

    task automatic modelStep();
        logic [WIDTH-1:0] v;
        bit corr;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ma[i] = '0; mb[i] = '0; mc[i] = '0;
            end
            ph = PH_OFF; gap = 0; sptr = 0; e_cnt = 0;
            e_ra = '0; e_rb = '0; e_rc = '0; e_rv = '0; e_flag = 1'b0; e_addr = 0;
            mvalid = 1'b1;
            return;
        end
        e_ra = ma[raddr]; e_rb = mb[raddr]; e_rc = mc[raddr];
        e_rv = vote(ma[raddr], mb[raddr], mc[raddr]);
        e_flag = 1'b0;
        corr = 1'b0;
        case (ph)
            PH_OFF: if (scrub_en) begin ph = PH_GAP; gap = SCRUB_DIV; end
            PH_GAP: begin
                if (!scrub_en) ph = PH_OFF;
                else begin
                    gap--;
                    if (gap == 0) ph = PH_SNAP;
                end
            end
            PH_SNAP: ph = scrub_en ? PH_FIX : PH_OFF;
            default: begin
                if (we) ph = PH_SNAP;
                else begin
                    if (differs(sptr)) begin
                        v = vote(ma[sptr], mb[sptr], mc[sptr]);
                        ma[sptr] = v; mb[sptr] = v; mc[sptr] = v;
                        corr = 1'b1; e_flag = 1'b1; e_addr = sptr;
                    end
                    sptr = (sptr + 1) % DEPTH;
                    if (scrub_en) begin ph = PH_GAP; gap = SCRUB_DIV; end
                    else ph = PH_OFF;
                end
            end
        endcase
        if (corr) e_cnt = cnt_clr ? 1 : ((e_cnt == 255) ? 255 : e_cnt + 1);
        else if (cnt_clr) e_cnt = 0;
        if (we) begin
            ma[waddr] = (inj_en && inj_sel == 2'd0) ? (wdata ^ inj_mask) : wdata;
            mb[waddr] = (inj_en && inj_sel == 2'd1) ? (wdata ^ inj_mask) : wdata;
            mc[waddr] = (inj_en && inj_sel == 2'd2) ? (wdata ^ inj_mask) : wdata;
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            checkOutput("cyc rdata_a", 32'(rdata_a), 32'(e_ra));
            checkOutput("cyc rdata_b", 32'(rdata_b), 32'(e_rb));
            checkOutput("cyc rdata_c", 32'(rdata_c), 32'(e_rc));
            checkOutput("cyc rdata_v", 32'(rdata_v), 32'(e_rv));
            checkOutput("cyc seu_flag", 32'(seu_flag), 32'(e_flag));
            checkOutput("cyc seu_addr", 32'(seu_addr), 32'(e_addr));
            checkOutput("cyc seu_cnt", 32'(seu_cnt), 32'(e_cnt));
            checkOutput("cyc busy", 32'(busy), 32'(ph != PH_OFF));
        end
    end

    int flag_total = 0;
    initial forever begin
        @(negedge clk);
        if (seu_flag === 1'b1) flag_total++;
    end

    task automatic applyStimulus(input logic w, input logic [AWIDTH-1:0] wa, input logic [WIDTH-1:0] wd,
                                 input logic [1:0] isel, input logic [WIDTH-1:0] imask,
                                 input logic [AWIDTH-1:0] ra);
        we = w; waddr = wa; wdata = wd;
        inj_sel = isel; inj_en = (isel != 2'd3); inj_mask = imask; raddr = ra;
    endtask

    task automatic stepIdle(input logic [AWIDTH-1:0] ra);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 2'd3, '0, ra);
    endtask

    task automatic stepWrite(input logic [AWIDTH-1:0] wa, input logic [WIDTH-1:0] wd,
                             input logic [1:0] isel, input logic [WIDTH-1:0] imask);
        @(negedge clk);
        applyStimulus(1'b1, wa, wd, isel, imask, wa);
    endtask

    int base, visits, visits_at_flag, corrections, hit_addr;
    bit found;

    initial begin
        rst_n = 1'b0; scrub_en = 1'b0; cnt_clr = 1'b0;
        applyStimulus(1'b0, '0, '0, 2'd3, '0, '0);
        repeat (3) stepIdle(0);
        rst_n = 1'b1;
        stepIdle(0);
        checkOutput("reset rdata_v", 32'(rdata_v), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset seu_cnt", 32'(seu_cnt), 32'h0);

        // 1: plain write/read
        stepWrite(3, 16'h1234, 2'd3, 16'h0);
        stepIdle(3);
        stepIdle(3);
        checkOutput("t1 rdata_a", 32'(rdata_a), 32'h1234);
        checkOutput("t1 rdata_b", 32'(rdata_b), 32'h1234);
        checkOutput("t1 rdata_c", 32'(rdata_c), 32'h1234);
        checkOutput("t1 rdata_v", 32'(rdata_v), 32'h1234);
        checkOutput("t1 seu_cnt", 32'(seu_cnt), 32'h0);
        checkOutput("t1 busy", 32'(busy), 32'h0);

        // 2: injected upset on copy B, then scrub it
        stepWrite(5, 16'hABCD, 2'd1, 16'h00F0);
        stepIdle(5);
        stepIdle(5);
        checkOutput("t2 rdata_b", 32'(rdata_b), 32'hAB3D);
        checkOutput("t2 rdata_a", 32'(rdata_a), 32'hABCD);
        checkOutput("t2 rdata_v", 32'(rdata_v), 32'hABCD);
        base = flag_total;
        scrub_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < DEPTH * STEP; i++) begin
            stepIdle(5);
            if (seu_flag === 1'b1) begin found = 1'b1; break; end
        end
        checkOutput("t2 flag seen", 32'(found), 32'h1);
        checkOutput("t2 seu_addr", 32'(seu_addr), 32'h5);
        checkOutput("t2 seu_cnt", 32'(seu_cnt), 32'h1);
        repeat (DEPTH * STEP) stepIdle(5);
        checkOutput("t2 single flag", 32'(flag_total - base), 32'h1);
        scrub_en = 1'b0;
        repeat (12) stepIdle(5);
        checkOutput("t2 reread b", 32'(rdata_b), 32'hABCD);

        // 3: three clean sweeps
        base = flag_total;
        scrub_en = 1'b1;
        repeat (3 * DEPTH * STEP) stepIdle(0);
        checkOutput("t3 busy", 32'(busy), 32'h1);
        checkOutput("t3 no flags", 32'(flag_total - base), 32'h0);
        scrub_en = 1'b0;
        repeat (12) stepIdle(0);
        checkOutput("t3 idle", 32'(busy), 32'h0);

        // 4: user writes during FIX hold off the correction of addr 7
        stepWrite(7, 16'h7777, 2'd2, 16'h0001);
        stepIdle(7);
        scrub_en = 1'b1;
        visits = 0; visits_at_flag = -1; found = 1'b0;
        for (int i = 0; i < 2 * DEPTH * STEP + 40; i++) begin
            @(negedge clk);
            if (seu_flag === 1'b1) begin found = 1'b1; visits_at_flag = visits; break; end
            if (ph == PH_FIX && sptr == 7 && visits < 4) begin
                applyStimulus(1'b1, 2, 16'h2220 + 16'(visits), 2'd3, '0, 7);
                visits++;
            end else begin
                applyStimulus(1'b0, '0, '0, 2'd3, '0, 7);
            end
        end
        checkOutput("t4 flag seen", 32'(found), 32'h1);
        checkOutput("t4 held visits", 32'(visits_at_flag), 32'h4);
        checkOutput("t4 seu_addr", 32'(seu_addr), 32'h7);
        checkOutput("t4 seu_cnt", 32'(seu_cnt), 32'h2);
        scrub_en = 1'b0;
        repeat (12) stepIdle(2);
        checkOutput("t4 addr2", 32'(rdata_a), 32'h2223);
        stepIdle(7);
        stepIdle(7);
        checkOutput("t4 addr7 c", 32'(rdata_c), 32'h7777);

        // 5: saturate the counter, then clear together with a correction
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 2'd3, '0, 0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checkOutput("t5 cleared", 32'(seu_cnt), 32'h0);
        scrub_en = 1'b1;
        corrections = 0;
        for (int i = 0; i < 300 * (STEP + 1); i++) begin
            @(negedge clk);
            if (seu_flag === 1'b1) corrections++;
            if (corrections == 259) break;
            if (ph == PH_GAP) applyStimulus(1'b1, 4'(sptr), 16'h5A5A, 2'd0, 16'h8000, 0);
            else              applyStimulus(1'b0, '0, '0, 2'd3, '0, 0);
        end
        checkOutput("t5 corrections", 32'(corrections), 32'd259);
        checkOutput("t5 saturated", 32'(seu_cnt), 32'hFF);
        found = 1'b0;
        for (int i = 0; i < 4 * STEP; i++) begin
            @(negedge clk);
            if (ph == PH_FIX && differs(sptr)) begin
                applyStimulus(1'b0, '0, '0, 2'd3, '0, 0);
                cnt_clr = 1'b1;
                @(negedge clk);
                cnt_clr = 1'b0;
                found = 1'b1;
                break;
            end
            if (ph == PH_GAP) applyStimulus(1'b1, 4'(sptr), 16'h5A5A, 2'd0, 16'h8000, 0);
            else              applyStimulus(1'b0, '0, '0, 2'd3, '0, 0);
        end
        checkOutput("t5 clr fix seen", 32'(found), 32'h1);
        checkOutput("t5 clr+fix cnt", 32'(seu_cnt), 32'h1);
        checkOutput("t5 clr+fix flag", 32'(seu_flag), 32'h1);

        // 6: reset while FIX has a mismatch pending
        found = 1'b0; hit_addr = 0;
        for (int i = 0; i < 4 * STEP; i++) begin
            @(negedge clk);
            if (ph == PH_FIX && differs(sptr)) begin
                hit_addr = sptr;
                applyStimulus(1'b0, '0, '0, 2'd3, '0, 4'(hit_addr));
                rst_n = 1'b0;
                @(negedge clk);
                found = 1'b1;
                break;
            end
            if (ph == PH_GAP) applyStimulus(1'b1, 4'(sptr), 16'h0F0F, 2'd1, 16'h0100, 0);
            else              applyStimulus(1'b0, '0, '0, 2'd3, '0, 0);
        end
        checkOutput("t6 fix reached", 32'(found), 32'h1);
        checkOutput("t6 seu_flag", 32'(seu_flag), 32'h0);
        checkOutput("t6 seu_cnt", 32'(seu_cnt), 32'h0);
        checkOutput("t6 seu_addr", 32'(seu_addr), 32'h0);
        checkOutput("t6 busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        scrub_en = 1'b0;
        applyStimulus(1'b0, '0, '0, 2'd3, '0, 4'(hit_addr));
        stepIdle(4'(hit_addr));
        checkOutput("t6 array a", 32'(rdata_a), 32'h0);
        checkOutput("t6 array b", 32'(rdata_b), 32'h0);
        checkOutput("t6 array v", 32'(rdata_v), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
